myproject_dense_accum: RTL

//  Downstream stage of the dense-layer signed multiplier. Consumes a stream of PROD_W-bit signed

---
 rtl/myproject_dense_pkg.sv | 19 +
 rtl/myproject_round_sat.sv | 46 ++++
 rtl/myproject_dense_accum.sv | 125 ++++++++++++
 3 files changed

// File: rtl/myproject_dense_pkg.sv
// Shared definitions for the dense-layer accumulate stage.
// Holds the datapath widths, the FSM state type and the output saturation limits.
package myproject_dense_pkg;

  localparam int PROD_W = 26;
  localparam int ACC_W  = 32;
  localparam int BIAS_W = 16;
  localparam int OUT_W  = 16;

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_t;

  // Largest and smallest representable OUT_W-bit two's-complement values
  localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

endpackage

// File: rtl/myproject_round_sat.sv
// Combinational shift / round / saturate of the accumulator into an activation.
// Ports:
//   acc  in  ACC_W  signed accumulator value
//   data out OUT_W  shifted, optionally rounded, saturated result
//   sat  out 1      result was clipped to the OUT_W range
module myproject_round_sat
  import myproject_dense_pkg::*;
#(
  parameter int SHIFT = 10,
  parameter int ROUND = 0
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] data,
  output logic             sat
);

  // One extra bit of headroom so the rounding add can never overflow
  localparam logic signed [ACC_W:0] RND_ADD =
    (ROUND != 0) ? ((ACC_W+1)'(1) << (SHIFT-1)) : (ACC_W+1)'(0);
  localparam logic signed [ACC_W:0] LIM_HI = {{(ACC_W+1-OUT_W){1'b0}}, SAT_MAX};
  localparam logic signed [ACC_W:0] LIM_LO = {{(ACC_W+1-OUT_W){1'b1}}, SAT_MIN};

  logic signed [ACC_W:0] w_ext;
  logic signed [ACC_W:0] w_rnd;
  logic signed [ACC_W:0] w_shr;

  // Sign-extend, round, arithmetic shift, then clip into the output range
  always_comb begin
    w_ext = signed'({acc[ACC_W-1], acc});
    w_rnd = w_ext + RND_ADD;
    w_shr = w_rnd >>> SHIFT;
    data  = w_shr[OUT_W-1:0];
    sat   = 1'b0;
    if (w_shr > LIM_HI) begin
      data = SAT_MAX;
      sat  = 1'b1;
    end else if (w_shr < LIM_LO) begin
      data = SAT_MIN;
      sat  = 1'b1;
    end else begin
      data = w_shr[OUT_W-1:0];
      sat  = 1'b0;
    end
  end

endmodule

// File: rtl/myproject_dense_accum.sv
// Dense-layer accumulate stage: sums one neuron's products onto its bias, then
// shifts/rounds/saturates the sum and offers it on a valid/ready output.
// Ports:
//   ap_clk, ap_rst                   clock, synchronous active-high reset
//   prod_data/valid/last/ready       product beat stream (ready depends on state only)
//   bias                             neuron bias, sampled on the first beat of a vector
//   out_data/valid/ready, out_sat    result handshake, sat qualified by out_valid
//   len_err                          sticky: a vector length differed from N_IN
module myproject_dense_accum
  import myproject_dense_pkg::*;
#(
  parameter int SHIFT = 10,
  parameter int N_IN  = 16,
  parameter int ROUND = 0
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_valid,
  input  logic              prod_last,
  output logic              prod_ready,
  input  logic [BIAS_W-1:0] bias,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sat,
  output logic              len_err
);

  localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [OUT_W-1:0]   r_out_data;
  logic               r_out_valid;
  logic               r_out_sat;
  logic               r_len_err;
  logic               r_prod_ready;

  logic [ACC_W-1:0]   w_bias_acc;
  logic [ACC_W-1:0]   w_prod_acc;
  logic [ACC_W-1:0]   w_base;
  logic [ACC_W-1:0]   w_sum;
  logic               w_cnt_last;
  logic               w_accept;
  logic               w_end;
  logic [OUT_W-1:0]   w_rs_data;
  logic               w_rs_sat;

  // Bias is already in output format, so align it to the product fraction
  assign w_bias_acc = {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias} << SHIFT;
  assign w_prod_acc = {{(ACC_W-PROD_W){prod_data[PROD_W-1]}}, prod_data};
  assign w_base     = (r_cnt == CNT_W'(0)) ? w_bias_acc : r_acc;
  assign w_sum      = w_base + w_prod_acc;
  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_accept   = prod_valid & r_prod_ready;
  assign w_end      = prod_last | w_cnt_last;

  // The result of the beat being accepted is formatted directly from w_sum
  myproject_round_sat #(
    .SHIFT (SHIFT),
    .ROUND (ROUND)
  ) u_round_sat (
    .acc  (w_sum),
    .data (w_rs_data),
    .sat  (w_rs_sat)
  );

  // Accumulate/output FSM; r_prod_ready mirrors (state == S_ACC)
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state      <= S_ACC;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_sat    <= 1'b0;
      r_len_err    <= 1'b0;
      r_prod_ready <= 1'b1;
    end else begin
      case (r_state)
        S_ACC: begin
          if (w_accept) begin
            r_acc <= w_sum;
            if (prod_last != w_cnt_last) begin
              r_len_err <= 1'b1;
            end
            if (w_end) begin
              r_out_data   <= w_rs_data;
              r_out_sat    <= w_rs_sat;
              r_out_valid  <= 1'b1;
              r_state      <= S_OUT;
              r_prod_ready <= 1'b0;
              r_cnt        <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid  <= 1'b0;
            r_state      <= S_ACC;
            r_prod_ready <= 1'b1;
          end
        end
        default: begin
          r_state      <= S_ACC;
          r_out_valid  <= 1'b0;
          r_prod_ready <= 1'b1;
          r_cnt        <= '0;
        end
      endcase
    end
  end

  assign prod_ready = r_prod_ready;
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign out_sat    = r_out_sat;
  assign len_err    = r_len_err;

endmodule
